separate_timestamp: RTL and testbench

Splits an AXI4-Stream of `[Ethernet frame]/[timestamp footer]` into two streams: the bare frame, and the timestamp as a single-beat side stream. It sits directly downstream of `connect_timestamp` and undoes its framing. Consumers that need the frame and its timestamp separately (ATS eligibility, egress scheduling) attach to its outputs. Because the footer trails the frame, the block holds back the last `TS_BEATS = TIMESTAMP_WIDTH/DATA_WIDTH` beats in a delay line. It then re-asserts `tlast` on the true last frame beat.

---
 rtl/ts_stream_pkg.sv | 20 ++
 rtl/ts_delay_line.sv | 54 +++++
 rtl/separate_timestamp.sv | 141 ++++++++++++++
 tb/tb_separate_timestamp.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ts_stream_pkg.sv
// Shared definitions for the timestamp framing blocks (connect/separate).
// Holds the default footer width, the footer byte order, the helper that
// turns a footer width into a beat count, and the separator FSM encoding.
package ts_stream_pkg;

    localparam int TS_WIDTH_DEFAULT = 72;

    // Footer beats are ordered least-significant slice first.
    localparam bit TS_FOOTER_LSB_FIRST = 1'b1;

    function automatic int ts_beats(input int ts_width, input int data_width);
        return ts_width / data_width;
    endfunction

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_TS_OUT  = 1'b1
    } ts_state_e;

endpackage

// File: rtl/ts_delay_line.sv
// Parametric shift register used to hold back the trailing footer beats.
// Ports:
//   clk                 rising-edge clock
//   clear               synchronous clear of all entries
//   push                shift in {in_data, in_keep} at the newest end
//   pop                 shift without a new beat (zero fill at newest end)
//   in_data / in_keep   beat to push
//   sr_data             flat contents, entry 0 (oldest) in the low bits
//   oldest_keep         tkeep of entry 0
// Once DEPTH beats have been pushed, entry 0 is the oldest beat; every push
// shifts toward entry 0, so a push on a full line is also the pop.
module ts_delay_line #(
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = 1,
    parameter int DEPTH      = 9
) (
    input  logic                        clk,
    input  logic                        clear,
    input  logic                        push,
    input  logic                        pop,
    input  logic [DATA_WIDTH-1:0]       in_data,
    input  logic [KEEP_WIDTH-1:0]       in_keep,
    output logic [DEPTH*DATA_WIDTH-1:0] sr_data,
    output logic [KEEP_WIDTH-1:0]       oldest_keep
);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q, data_d;
    logic [DEPTH-1:0][KEEP_WIDTH-1:0] keep_q, keep_d;

    always_comb begin
        data_d = data_q;
        keep_d = keep_q;
        if (clear) begin
            data_d = '0;
            keep_d = '0;
        end else if (push || pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                data_d[i] = data_q[i+1];
                keep_d[i] = keep_q[i+1];
            end
            data_d[DEPTH-1] = push ? in_data : '0;
            keep_d[DEPTH-1] = push ? in_keep : '0;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
        keep_q <= keep_d;
    end

    assign sr_data     = data_q;
    assign oldest_keep = keep_q[0];

endmodule

// File: rtl/separate_timestamp.sv
// Splits an AXI4-Stream of [frame][timestamp footer] into the bare frame and
// a single-beat timestamp side stream. The last TS_BEATS input beats are held
// back in a delay line so that the footer never reaches m_axis; the frame's
// tlast is regenerated from the input tlast.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   s_axis_*                       frame followed by footer (input)
//   m_axis_*                       frame only (output)
//   m_axis_timestamp_tdata/tvalid/tready   extracted timestamp
//   err_short_frame                one-cycle pulse when a runt is dropped
module separate_timestamp
    import ts_stream_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
    parameter int TIMESTAMP_WIDTH = TS_WIDTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]      s_axis_tkeep,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic                       s_axis_tlast,
    output logic [DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]      m_axis_tkeep,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic [TIMESTAMP_WIDTH-1:0] m_axis_timestamp_tdata,
    output logic                       m_axis_timestamp_tvalid,
    input  logic                       m_axis_timestamp_tready,
    output logic                       err_short_frame
);

    localparam int TS_BEATS = ts_beats(TIMESTAMP_WIDTH, DATA_WIDTH);
    localparam int CNT_W    = $clog2(TS_BEATS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TS_BEATS);

    if ((TIMESTAMP_WIDTH % DATA_WIDTH) != 0 || (DATA_WIDTH % 8) != 0 ||
        !TS_FOOTER_LSB_FIRST) begin : g_bad_cfg
        $fatal(1, "separate_timestamp: TIMESTAMP_WIDTH must be a multiple of DATA_WIDTH");
    end

    ts_state_e                state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [TIMESTAMP_WIDTH-1:0] ts_q, ts_d;
    logic                     err_q, err_d;

    logic [TIMESTAMP_WIDTH-1:0] sr_data;
    logic [KEEP_WIDTH-1:0]      oldest_keep;
    logic                       full, s_fire, ts_fire;

    ts_delay_line #(
        .DATA_WIDTH (DATA_WIDTH),
        .KEEP_WIDTH (KEEP_WIDTH),
        .DEPTH      (TS_BEATS)
    ) u_dly (
        .clk         (clk),
        .clear       (rst),
        .push        (s_fire),
        .pop         (m_axis_tvalid & m_axis_tready),
        .in_data     (s_axis_tdata),
        .in_keep     (s_axis_tkeep),
        .sr_data     (sr_data),
        .oldest_keep (oldest_keep)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ts_d    = ts_q;
        err_d   = 1'b0;

        full                    = (cnt_q == CNT_FULL);
        s_axis_tready           = 1'b0;
        m_axis_tvalid           = 1'b0;
        m_axis_timestamp_tvalid = 1'b0;

        // Handshake outputs are forced idle while reset is held.
        if (!rst) begin
            case (state_q)
                ST_COLLECT: begin
                    if (!full) begin
                        s_axis_tready = 1'b1;
                    end else begin
                        m_axis_tvalid = s_axis_tvalid;
                        s_axis_tready = m_axis_tready;
                    end
                end
                default: m_axis_timestamp_tvalid = 1'b1;
            endcase
        end

        s_fire  = s_axis_tvalid & s_axis_tready;
        ts_fire = m_axis_timestamp_tvalid & m_axis_timestamp_tready;

        if (s_fire) begin
            if (s_axis_tlast) begin
                if (full) begin
                    // After this push the line holds exactly the footer, so
                    // capture the post-shift contents.
                    ts_d    = TIMESTAMP_WIDTH'({s_axis_tdata, sr_data} >> DATA_WIDTH);
                    state_d = ST_TS_OUT;
                end else begin
                    // Runt: nothing was emitted, just drop it.
                    cnt_d = '0;
                    err_d = 1'b1;
                end
            end else if (!full) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (ts_fire) begin
            cnt_d   = '0;
            state_d = ST_COLLECT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_COLLECT;
            cnt_q   <= '0;
            ts_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ts_q    <= ts_d;
            err_q   <= err_d;
        end
    end

    assign m_axis_tdata           = sr_data[DATA_WIDTH-1:0];
    assign m_axis_tkeep           = oldest_keep;
    assign m_axis_tlast           = s_axis_tlast;
    assign m_axis_timestamp_tdata = ts_q;
    assign err_short_frame        = err_q;

endmodule

// File: tb/tb_separate_timestamp.sv
module tb_separate_timestamp;

    localparam int DW  = 8;
    localparam int KW  = 1;
    localparam int TSW = 72;
    localparam int NB  = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [DW-1:0]  s_data  = '0;
    logic [KW-1:0]  s_keep  = '0;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic           s_last  = 1'b0;
    logic [DW-1:0]  m_data;
    logic [KW-1:0]  m_keep;
    logic           m_valid;
    logic           m_ready = 1'b1;
    logic           m_last;
    logic [TSW-1:0] ts_data;
    logic           ts_valid;
    logic           ts_ready = 1'b1;
    logic           err;

    separate_timestamp #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .TIMESTAMP_WIDTH(TSW)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .s_axis_tdata            (s_data),
        .s_axis_tkeep            (s_keep),
        .s_axis_tvalid           (s_valid),
        .s_axis_tready           (s_ready),
        .s_axis_tlast            (s_last),
        .m_axis_tdata            (m_data),
        .m_axis_tkeep            (m_keep),
        .m_axis_tvalid           (m_valid),
        .m_axis_tready           (m_ready),
        .m_axis_tlast            (m_last),
        .m_axis_timestamp_tdata  (ts_data),
        .m_axis_timestamp_tvalid (ts_valid),
        .m_axis_timestamp_tready (ts_ready),
        .err_short_frame         (err)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    beat_t          exp_q[$];
    logic [TSW-1:0] exp_ts[$];
    int n_cmp = 0, n_err = 0;
    int err_seen = 0, err_exp = 0;
    bit rnd_m = 0, ts_hold = 0;

    task automatic chk(input string name, input logic [TSW-1:0] act, input logic [TSW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Ready generators, updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        m_ready  = rnd_m ? 1'($urandom_range(0, 1)) : 1'b1;
        ts_ready = !ts_hold;
    end

    // Monitor: pops the scoreboard whenever the DUT completes a handshake.
    beat_t mon_e;
    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid && m_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL m_beat: got unexpected beat %h last=%b, required none", m_data, m_last);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({m_data, m_keep, m_last} !== mon_e) begin
                        n_err++;
                        $display("FAIL m_beat: got d=%h k=%h l=%b, required d=%h k=%h l=%b",
                                 m_data, m_keep, m_last, mon_e.d, mon_e.k, mon_e.l);
                    end
                end
            end
            if (ts_valid && ts_ready) begin
                n_cmp++;
                if (exp_ts.size() == 0) begin
                    n_err++;
                    $display("FAIL ts: got unexpected timestamp %h, required none", ts_data);
                end else begin
                    logic [TSW-1:0] e;
                    e = exp_ts.pop_front();
                    if (ts_data !== e) begin
                        n_err++;
                        $display("FAIL ts: got %h, required %h", ts_data, e);
                    end
                end
            end
            if (err) err_seen++;
        end
    end

    function automatic logic [DW-1:0] fbyte(input int fid, input int i);
        return DW'(fid * 37 + i);
    endfunction

    task automatic put_beat(input logic [DW-1:0] d, input logic l, input bit rnd);
        int  guard;
        bit  fired;
        if (rnd) begin
            repeat ($urandom_range(0, 2)) begin
                s_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        s_valid = 1'b1; s_data = d; s_keep = '1; s_last = l;
        fired = 0; guard = 0;
        while (!fired) begin
            @(negedge clk);
            fired = s_ready;
            @(posedge clk); #1;
            guard++;
            if (!fired && guard > 500) begin
                n_cmp++; n_err++;
                $display("FAIL in_handshake: got no s_axis_tready in %0d cycles, required a handshake", guard);
                fired = 1;
            end
        end
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    // len = 0 sends a runt (footer only). stop > 0 drives only that many beats.
    task automatic send_frame(input int len, input logic [TSW-1:0] ts, input int fid,
                              input bit rnd, input int stop);
        int total, lim;
        total = len + NB;
        lim   = (stop > 0) ? stop : total;
        for (int i = 0; i < len; i++)
            if (stop == 0 || i + NB < stop)
                exp_q.push_back({fbyte(fid, i), KW'(1), (i == len - 1)});
        if (stop == 0) begin
            if (len > 0) exp_ts.push_back(ts);
            else         err_exp++;
        end
        for (int j = 0; j < lim; j++) begin
            if (j < len) put_beat(fbyte(fid, j), j == total - 1, rnd);
            else         put_beat(ts[(j - len) * DW +: DW], j == total - 1, rnd);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation timeout, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int bad;
        // Reset state
        @(negedge clk);
        chk("rst_s_ready", TSW'(s_ready), 0);
        chk("rst_m_valid", TSW'(m_valid), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_ts_valid", TSW'(ts_valid), 0);
        chk("reset_ts_data", ts_data, 0);
        chk("reset_err", TSW'(err), 0);
        chk("reset_m_valid", TSW'(m_valid), 0);
        chk("reset_s_ready", TSW'(s_ready), 1);
        @(posedge clk); #1;

        // 64-byte frame, all readies high; timestamp valid one cycle after tlast
        send_frame(64, 72'hABFEDCBA9876543210, 1, 0, 0);
        chk("ts_valid_latency", TSW'(ts_valid), 1);
        chk("ts_value_t1", ts_data, 72'hABFEDCBA9876543210);
        @(posedge clk); #1;

        // Random valid and 50% output ready
        rnd_m = 1;
        send_frame(64,  72'h0123456789ABCDEF01, 2, 1, 0);
        send_frame(100, 72'hFFEEDDCCBBAA998877, 3, 1, 0);
        send_frame(60,  72'h00000000000000001F, 4, 1, 0);
        rnd_m = 0;
        repeat (3) @(posedge clk); #1;

        // Timestamp backpressure for 20 cycles
        ts_hold = 1;
        send_frame(70, 72'h5A5A5A5A5AA5A5A5A5, 5, 0, 0);
        fork
            send_frame(64, 72'h112233445566778899, 6, 0, 0);
            begin
                bad = 0;
                repeat (20) begin
                    @(negedge clk);
                    if (s_ready || m_valid || !ts_valid) bad++;
                end
                chk("ts_backpressure_stall", TSW'(bad), 0);
                ts_hold = 0;
            end
        join
        @(posedge clk); #1;

        // Runt of 9 beats, then a 60-byte frame
        send_frame(0, 72'hDEADBEEFCAFEF00D42, 7, 0, 0);
        repeat (3) @(posedge clk); #1;
        chk("runt_err_pulse_cycles", TSW'(err_seen), TSW'(err_exp));
        send_frame(60, 72'h0F0E0D0C0B0A090807, 8, 0, 0);

        // Back-to-back 1 byte and 1514 bytes
        send_frame(1,    72'h000000000000000001, 9, 0, 0);
        send_frame(1514, 72'h800000000000000002, 10, 0, 0);
        @(posedge clk); #1;

        // Reset after 30 input beats of a frame
        send_frame(64, 72'h13579BDF02468ACE11, 11, 0, 30);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_s_ready", TSW'(s_ready), 0);
        chk("midrst_m_valid", TSW'(m_valid), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_ts_valid", TSW'(ts_valid), 0);
        chk("postrst_ts_data", ts_data, 0);
        chk("postrst_err", TSW'(err), 0);
        chk("postrst_m_valid", TSW'(m_valid), 0);
        @(posedge clk); #1;
        send_frame(64, 72'hA1B2C3D4E5F6071829, 12, 0, 0);

        repeat (20) @(posedge clk);
        chk("exp_beats_left", TSW'(exp_q.size()), 0);
        chk("exp_ts_left", TSW'(exp_ts.size()), 0);
        chk("err_pulse_total", TSW'(err_seen), TSW'(err_exp));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
